// File: rtl/regfile_write_sequencer.sv
// regfile_write_sequencer
//   Write-side driver for the 7x8-bit register array. Write-back requests arrive
//   over a valid/ready handshake and are buffered in an in-order FIFO. The head is
//   issued as at most one register write per cycle on ce0..ce6 / di0..di6.
//   A pending-write bitmap is exported for read-after-write hazard checks in decode.
//
//   Optional feature macro: RF_WR_BYPASS_EN
//     defined   - a request accepted while the FIFO is empty skips the FIFO and goes
//                 straight to the output stage on the accept edge.
//     undefined - every request passes through the FIFO.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   wb_valid  write request valid
//   wb_addr   target register 0..7 (RO_REG and 7 are discarded with wr_err)
//   wb_data   write data
//   wb_ready  request accepted when wb_valid && wb_ready (combinational from state)
//   ce0..ce6  registered one-hot write enables to the array
//   di0..di6  registered write data to the array (all carry the same value)
//   pend      bit n set while a write to register n is buffered or on ce/di
//   level     FIFO occupancy
//   wr_err    one-cycle pulse when a write to RO_REG or address 7 is discarded
module regfile_write_sequencer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned RO_REG = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wb_valid,
    input  logic [2:0]                   wb_addr,
    input  logic [7:0]                   wb_data,
    output logic                         wb_ready,
    output logic                         ce0,
    output logic                         ce1,
    output logic                         ce2,
    output logic                         ce3,
    output logic                         ce4,
    output logic                         ce5,
    output logic                         ce6,
    output logic [7:0]                   di0,
    output logic [7:0]                   di1,
    output logic [7:0]                   di2,
    output logic [7:0]                   di3,
    output logic [7:0]                   di4,
    output logic [7:0]                   di5,
    output logic [7:0]                   di6,
    output logic [6:0]                   pend,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         wr_err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [2:0] addr;
        logic [7:0] data;
    } wb_entry_t;

    wb_entry_t       mem [DEPTH];
    logic [AW-1:0]   rd_ptr_q, wr_ptr_q, rd_ptr_d, wr_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [6:0]      ce_q, ce_d;
    logic [7:0]      di_q, di_d;
    logic [6:0]      pend_q, pend_d;
    logic            err_q, err_d;

    logic            push, pop, bypass, fifo_push, load;
    wb_entry_t       new_entry, sel, e;
    logic [AW-1:0]   idx;

    // Write-enable pattern for an address; RO_REG and 7 never produce an enable.
    function automatic logic [6:0] onehot(input logic [2:0] a);
        logic [6:0] r;
        r = '0;
        for (int unsigned n = 0; n < 7; n++) begin
            r[n] = (a == 3'(n)) && (n != RO_REG);
        end
        return r;
    endfunction

    assign wb_ready = (level_q != LW'(DEPTH));

    // Next-state: FIFO bookkeeping, output stage and pending bitmap.
    always_comb begin
        push      = wb_valid && wb_ready;
        pop       = (level_q != '0);
`ifdef RF_WR_BYPASS_EN
        bypass    = push && (level_q == '0);
`else
        bypass    = 1'b0;
`endif
        fifo_push = push && !bypass;
        new_entry = '{addr: wb_addr, data: wb_data};

        // pop and bypass are exclusive: bypass only happens when level is 0
        load = pop || bypass;
        sel  = pop ? mem[rd_ptr_q] : new_entry;

        ce_d  = load ? onehot(sel.addr) : 7'b0;
        di_d  = (ce_d != 7'b0) ? sel.data : di_q;
        err_d = load && (ce_d == 7'b0);

        rd_ptr_d = pop       ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d = fifo_push ? wr_ptr_q + AW'(1) : wr_ptr_q;

        level_d = level_q;
        if (fifo_push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (!fifo_push && pop) begin
            level_d = level_q - LW'(1);
        end

        // Pending bitmap as it will be after this edge: next output stage plus
        // every entry that will still sit in the FIFO.
        pend_d = ce_d;
        idx    = '0;
        e      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_d + AW'(i);
            e   = (fifo_push && (idx == wr_ptr_q)) ? new_entry : mem[idx];
            if (LW'(i) < level_d) begin
                pend_d = pend_d | onehot(e.addr);
            end
        end
    end

    // State registers; reset wins over every other event on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            ce_q     <= '0;
            di_q     <= '0;
            pend_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            ce_q     <= ce_d;
            di_q     <= di_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
        end
    end

    // FIFO storage; contents are don't-care while level says the slot is empty.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            mem[wr_ptr_q] <= new_entry;
        end
    end

    assign {ce6, ce5, ce4, ce3, ce2, ce1, ce0} = ce_q;
    assign di0    = di_q;
    assign di1    = di_q;
    assign di2    = di_q;
    assign di3    = di_q;
    assign di4    = di_q;
    assign di5    = di_q;
    assign di6    = di_q;
    assign pend   = pend_q;
    assign level  = level_q;
    assign wr_err = err_q;

endmodule

// File: tb/tb_regfile_write_sequencer.sv
module tb_regfile_write_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       wb_valid;
    logic [2:0] wb_addr;
    logic [7:0] wb_data;
    logic       wb_ready;
    logic       ce0, ce1, ce2, ce3, ce4, ce5, ce6;
    logic [7:0] di0, di1, di2, di3, di4, di5, di6;
    logic [6:0] pend;
    logic [2:0] level;
    logic       wr_err;

    int total = 0;
    int bad   = 0;

`ifdef RF_WR_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    logic [7:0] exp_di;
    logic [6:0] ce_v;
    logic [7:0] di_arr [7];

    assign ce_v = {ce6, ce5, ce4, ce3, ce2, ce1, ce0};
    always_comb begin
        di_arr[0] = di0; di_arr[1] = di1; di_arr[2] = di2; di_arr[3] = di3;
        di_arr[4] = di4; di_arr[5] = di5; di_arr[6] = di6;
    end

    regfile_write_sequencer #(.DEPTH(4), .RO_REG(6)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
        .ce0(ce0), .ce1(ce1), .ce2(ce2), .ce3(ce3), .ce4(ce4), .ce5(ce5), .ce6(ce6),
        .di0(di0), .di1(di1), .di2(di2), .di3(di3), .di4(di4), .di5(di5), .di6(di6),
        .pend(pend), .level(level), .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wb_valid = 1'b0; wb_addr = 3'd0; wb_data = 8'h00;
        step();
        step();
        rst = 1'b0;
        total++; if (ce_v !== 7'b0) begin bad++; $display("FAIL reset_ce got=%b want=0000000", ce_v); end
        for (int n = 0; n < 7; n++) begin
            total++;
            if (di_arr[n] !== 8'h00) begin bad++; $display("FAIL reset_di%0d got=%h want=00", n, di_arr[n]); end
        end
        total++; if (pend !== 7'b0) begin bad++; $display("FAIL reset_pend got=%b want=0000000", pend); end
        total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
        total++; if (wb_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", wb_ready); end
        total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", wr_err); end
    endtask

    task automatic test_single();
        int first = -1;
        int n_hi  = 0;
        wb_valid = 1'b1; wb_addr = 3'd2; wb_data = 8'hA5;
        step();
        wb_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            if (ce_v[2] === 1'b1) begin
                n_hi++;
                if (first < 0) first = k;
                total++; if (di2 !== 8'hA5) begin bad++; $display("FAIL single_di2 got=%h want=a5", di2); end
            end
            total++;
            if ((ce_v & 7'b1111011) !== 7'b0) begin bad++; $display("FAIL single_other_ce k=%0d got=%b want=0", k, ce_v); end
            total++;
            if (pend !== ((k <= LAT) ? 7'b0000100 : 7'b0)) begin
                bad++; $display("FAIL single_pend k=%0d got=%b want=%b", k, pend, (k <= LAT) ? 7'b0000100 : 7'b0);
            end
        end
        total++; if (first !== LAT) begin bad++; $display("FAIL single_latency got=%0d want=%0d", first, LAT); end
        total++; if (n_hi !== 1) begin bad++; $display("FAIL single_ce_cycles got=%0d want=1", n_hi); end
        exp_di = 8'hA5;
    endtask

    task automatic test_stream();
        int         j;
        logic [6:0] exp_ce;
        for (int k = 0; k < 10; k++) begin
            if (k < 6) begin
                wb_valid = 1'b1; wb_addr = 3'(k); wb_data = 8'h10 + 8'(k);
                total++; if (wb_ready !== 1'b1) begin bad++; $display("FAIL stream_ready k=%0d got=%b want=1", k, wb_ready); end
            end else begin
                wb_valid = 1'b0;
            end
            step();
            j      = k - LAT;
            exp_ce = (j >= 0 && j < 6) ? (7'b1 << j) : 7'b0;
            total++; if (ce_v !== exp_ce) begin bad++; $display("FAIL stream_ce k=%0d got=%b want=%b", k, ce_v, exp_ce); end
            if (exp_ce != 7'b0) begin
                total++;
                if (di_arr[j] !== 8'h10 + 8'(j)) begin bad++; $display("FAIL stream_di k=%0d got=%h want=%h", k, di_arr[j], 8'h10 + 8'(j)); end
            end
            total++;
            if (level !== ((k < 6) ? 3'(LAT) : 3'd0)) begin
                bad++; $display("FAIL stream_level k=%0d got=%0d want=%0d", k, level, (k < 6) ? LAT : 0);
            end
        end
        exp_di = 8'h15;
    endtask

    // Burst with repeated targets: order is preserved and both r4 writes issue.
    task automatic test_burst();
        logic [2:0] addrs [5];
        logic [7:0] datas [5];
        int         j;
        addrs[0] = 3'd4; addrs[1] = 3'd4; addrs[2] = 3'd1; addrs[3] = 3'd0; addrs[4] = 3'd4;
        datas[0] = 8'hA1; datas[1] = 8'hA2; datas[2] = 8'hB0; datas[3] = 8'hC0; datas[4] = 8'hD5;
        for (int k = 0; k < 8; k++) begin
            if (k < 5) begin
                wb_valid = 1'b1; wb_addr = addrs[k]; wb_data = datas[k];
            end else begin
                wb_valid = 1'b0;
            end
            total++; if (wb_ready !== 1'b1) begin bad++; $display("FAIL burst_ready k=%0d got=%b want=1", k, wb_ready); end
            step();
            j = k - LAT;
            if (j >= 0 && j < 5) begin
                total++;
                if (ce_v !== (7'b1 << addrs[j])) begin bad++; $display("FAIL burst_ce k=%0d got=%b want=%b", k, ce_v, 7'b1 << addrs[j]); end
                total++;
                if (di0 !== datas[j]) begin bad++; $display("FAIL burst_di k=%0d got=%h want=%h", k, di0, datas[j]); end
            end else begin
                total++; if (ce_v !== 7'b0) begin bad++; $display("FAIL burst_idle_ce k=%0d got=%b want=0", k, ce_v); end
            end
        end
        exp_di = 8'hD5;
    endtask

    task automatic test_bad_addr();
        logic exp_err;
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                wb_valid = 1'b1; wb_addr = 3'd6; wb_data = 8'hFF;
            end else if (k == 1) begin
                wb_valid = 1'b1; wb_addr = 3'd7; wb_data = 8'h5A;
            end else begin
                wb_valid = 1'b0;
            end
            step();
            exp_err = (k == LAT) || (k == LAT + 1);
            total++; if (wr_err !== exp_err) begin bad++; $display("FAIL bad_err k=%0d got=%b want=%b", k, wr_err, exp_err); end
            total++; if (ce_v !== 7'b0) begin bad++; $display("FAIL bad_ce k=%0d got=%b want=0", k, ce_v); end
            total++; if (pend !== 7'b0) begin bad++; $display("FAIL bad_pend k=%0d got=%b want=0", k, pend); end
            total++; if (di6 !== exp_di) begin bad++; $display("FAIL bad_di k=%0d got=%h want=%h", k, di6, exp_di); end
        end
    endtask

    // Reset lands on the edge where the second r3 write would be issued.
    task automatic test_reset_midflight();
        wb_valid = 1'b1; wb_addr = 3'd3; wb_data = 8'h11;
        step();
`ifdef RF_WR_BYPASS_EN
        total++; if (ce_v !== 7'b0001000) begin bad++; $display("FAIL rst_first_ce got=%b want=0001000", ce_v); end
        total++; if (di3 !== 8'h11) begin bad++; $display("FAIL rst_first_di got=%h want=11", di3); end
        wb_data = 8'h22; rst = 1'b1;
        step();
`else
        wb_data = 8'h22;
        step();
        total++; if (ce_v !== 7'b0001000) begin bad++; $display("FAIL rst_first_ce got=%b want=0001000", ce_v); end
        total++; if (di3 !== 8'h11) begin bad++; $display("FAIL rst_first_di got=%h want=11", di3); end
        wb_valid = 1'b0; rst = 1'b1;
        step();
`endif
        wb_valid = 1'b0; rst = 1'b0;
        total++; if (ce_v !== 7'b0) begin bad++; $display("FAIL rst_ce got=%b want=0", ce_v); end
        total++; if (di3 !== 8'h00) begin bad++; $display("FAIL rst_di got=%h want=00", di3); end
        total++; if (level !== 3'd0) begin bad++; $display("FAIL rst_level got=%0d want=0", level); end
        total++; if (pend !== 7'b0) begin bad++; $display("FAIL rst_pend got=%b want=0", pend); end
        total++; if (wb_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", wb_ready); end
        for (int k = 0; k < 3; k++) begin
            step();
            total++; if (ce_v !== 7'b0) begin bad++; $display("FAIL rst_lost_ce k=%0d got=%b want=0", k, ce_v); end
        end
    endtask

    initial begin
        exp_di = 8'h00;
        test_reset();
        test_single();
        test_stream();
        test_burst();
        test_bad_addr();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
